mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle memory responder for the MIPS32 datapath. It serves a unified instruction/data word memory and answers the single-ported read/write strobes issued by the controller (fetch, load, store) after a configurable number of wait states. It reports completion with a one-cycle `ready` pulse and a `busy` level, so the controller can stall its current state until the access finishes.

## Interface
- `ADDR_W`, 10: word-address bits; memory depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: extra wait states per access; legal range 0..15.
- `clk`  in  1  clock, all state updates on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  read request strobe.
- `mem_write`  in  1  write request strobe.
- `addr`  in  32  byte address from the PC/ALU-result mux.
- `wdata`  in  32  store data (register B).
- `rdata`  out  32  read data; registered, held until the next successful read completes.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is in flight (state != IDLE).
- `err`  out  1  high together with `ready` when the request was rejected.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: strobes are sampled on every rising edge. If `mem_read | mem_write` = 1, the request is accepted: `addr`, `wdata` and the operation type are latched.
  - Request is legal (exactly one strobe high and `addr[1:0]` = 0):
    - WAIT_CYCLES > 0: load `wait_cnt` = WAIT_CYCLES - 1 and go to WAIT.
    - WAIT_CYCLES = 0: go to RESP and perform the access on that same edge.
  - Request is illegal (both strobes high, or `addr[1:0]` != 0): latch error flag, go to RESP, no memory access.
- WAIT: decrement `wait_cnt` each edge. On the edge where `wait_cnt` = 0, perform the access and go to RESP.
- Access, on the edge entering RESP:
  - Read: `rdata` <= mem[latched_addr[ADDR_W+1:2]].
  - Write: mem[latched_addr[ADDR_W+1:2]] <= latched_wdata; `rdata` unchanged.
- RESP: `ready` = 1 and `err` = error flag for exactly this cycle. Unconditionally return to IDLE on the next edge.
- Strobes are ignored in WAIT and RESP.
  - Requester holds strobes until it sees `ready`, then drops them before the next edge.
  - A strobe still high in the IDLE cycle after RESP starts a new access. This is intended back-to-back behaviour.
- Address bits [31:ADDR_W+2] are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes. This is not an error.
- Rejected request: memory and `rdata` are untouched.
- Memory array has no reset; contents are undefined until written or preloaded by the bench.

## Timing
- Reset (`nrst` = 0, async):
  - State = IDLE, `wait_cnt` = 0, `rdata` = 32'h0.
  - `ready` = 0, `busy` = 0, `err` = 0.
- Reset mid-operation: an in-flight request is aborted. A pending write is not committed. No `ready` pulse occurs after release.
- Legal access accepted at edge k: `ready` is high in the cycle following edge k+WAIT_CYCLES.
  - Total latency is WAIT_CYCLES+1 edges; WAIT_CYCLES = 0 gives `ready` in the cycle right after acceptance.
- Illegal request accepted at edge k: `ready` = `err` = 1 in the cycle after edge k, independent of WAIT_CYCLES.
- `busy` rises in the cycle after acceptance and falls in the cycle after RESP.
  - `busy` = 1 during RESP.
- `rdata` is valid from the RESP cycle onward; it is stable whenever `busy` = 0.
- Throughput: one access per WAIT_CYCLES+2 cycles with strobes held continuously.
- `ready` and `err` are registered outputs (decoded from state/flag registers only); no combinational path from inputs.

## Test plan
- Reset, then write 32'hDEADBEEF to addr 0x10 and read addr 0x10 with WAIT_CYCLES = 2:
  - Each `ready` pulse arrives 3 edges after acceptance.
  - Read returns 32'hDEADBEEF with `err` = 0.
- WAIT_CYCLES = 0, back-to-back reads of 0x0 and 0x4 with strobe held high:
  - Two `ready` pulses 2 cycles apart, correct data each time.
  - `busy` low for exactly one cycle between the two accesses.
- Read of addr 0x13 (misaligned):
  - `ready` = `err` = 1 one cycle after acceptance.
  - `rdata` keeps its previous value; memory unchanged.
- Both strobes high at addr 0x20:
  - Error response; a subsequent read of 0x20 returns the prior contents.
- Write 32'h12345678 to addr 0x4 + 2^(ADDR_W+2):
  - A read of 0x4 returns 32'h12345678 (wrap-around).
- Assert `nrst` low during WAIT of a write of 32'hCAFEF00D to 0x8:
  - Outputs return to reset values; no `ready` pulse.
  - A read of 0x8 returns the old value.

Source files
------------

// File: rtl/mem_responder.sv
// Multi-cycle word memory responder for the MIPS32 controller: one access per request,
// completed after WAIT_CYCLES wait states with a one-cycle ready pulse.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  // state  | meaning
  // S_IDLE | sampling strobes, accepts a request on any edge where one is high
  // S_WAIT | counting wait states down; access happens on the edge leaving at zero
  // S_RESP | ready (and err for rejected requests) asserted for this one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_wdata;
  logic              lat_write;
  logic              err_flag;
  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              req_legal;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_write;
  logic              do_access;
  logic              unused_addr;

  assign req         = mem_read | mem_write;
  assign req_legal   = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
  assign unused_addr = ^addr[31:ADDR_W+2];

  // With no wait states the access uses the live request on the accepting edge;
  // otherwise it uses the latched request on the edge leaving WAIT.
  always_comb begin
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
    acc_write = lat_write;
    do_access = 1'b0;
    if (state == S_IDLE) begin
      acc_idx   = addr[ADDR_W+1:2];
      acc_wdata = wdata;
      acc_write = mem_write;
      do_access = nrst && req && req_legal && (WAIT_CYCLES == 0);
    end else if (state == S_WAIT) begin
      do_access = nrst && (wait_cnt == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!req_legal || (WAIT_CYCLES == 0)) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    ready = (state == S_RESP);
    err   = (state == S_RESP) && err_flag;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt  <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= 32'h0;
      lat_write <= 1'b0;
      err_flag  <= 1'b0;
      rdata     <= 32'h0;
    end else begin
      if (state == S_IDLE && req) begin
        lat_idx   <= addr[ADDR_W+1:2];
        lat_wdata <= wdata;
        lat_write <= mem_write;
        err_flag  <= !req_legal;
        if (req_legal && (WAIT_CYCLES > 0)) begin
          wait_cnt <= WAIT_INIT;
        end
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access && !acc_write) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  // Storage carries no reset; a reset during WAIT suppresses do_access so no write commits.
  always_ff @(posedge clk) begin
    if (do_access && acc_write) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with no wait states, one with two,
// directed scenarios plus a randomized run against a word-array reference model.
module tb_mem_responder;

  logic              clk = 1'b0;
  logic              nrst;
  logic [1:0]        rd, wr;
  logic [1:0][31:0]  ad, wd;
  logic [31:0]       rdata0, rdata1;
  logic [1:0]        ready_o, busy_o, err_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl [2][1024];
  bit          mv  [2][1024];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .nrst(nrst), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdata0), .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0])
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .nrst(nrst), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdata1), .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  task automatic model_predict(input int d, input bit r, input bit w, input logic [31:0] a,
                               output int el, output bit ee, output logic [31:0] ed);
    bit legal;
    legal = (r != w) && (a % 4 == 0);
    el = legal ? wc(d) + 1 : 1;
    ee = !legal;
    ed = (legal && r) ? mdl[d][widx(a)] : last_rd[d];
  endtask

  task automatic model_commit(input int d, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] wdat);
    if ((r != w) && (a % 4 == 0)) begin
      if (w) begin
        mdl[d][widx(a)] = wdat;
        mv[d][widx(a)]  = 1'b1;
      end else begin
        last_rd[d] = mdl[d][widx(a)];
      end
    end
  endtask

  // Issues one request, waits (bounded) for ready; lat counts edges from acceptance, -1 on timeout.
  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] wdat, output logic [31:0] rdo, output bit e,
                      output int lat);
    @(negedge clk);
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = wdat;
    lat = -1; e = 1'b0; rdo = 32'hx;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (ready_o[d]) begin
        lat = j;
        e   = err_o[d];
        rdo = rdata_of(d);
        break;
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    model_commit(d, r, w, a, wdat);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    rd = '0; wr = '0; ad = '0; wd = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdata_of(d) !== 32'h0) begin
        failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdata_of(d));
      end
      checks++;
      if ({ready_o[d], busy_o[d], err_o[d]} !== 3'b000) begin
        failures++; $display("FAIL reset_flags dut%0d got rdy/busy/err=%b exp=000", d,
                             {ready_o[d], busy_o[d], err_o[d]});
      end
      last_rd[d] = 32'h0;
    end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [31:0] r; bit e; int lat;
    xfer(1, 0, 1, 32'h10, 32'hDEADBEEF, r, e, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
    @(negedge clk);
    checks++;
    if ({ready_o[1], busy_o[1]} !== 2'b00) begin
      failures++; $display("FAIL ready_single_cycle got rdy/busy=%b exp=00", {ready_o[1], busy_o[1]});
    end
    xfer(1, 1, 0, 32'h10, 32'h0, r, e, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      failures++; $display("FAIL rd_data got=%h err=%b exp=deadbeef err=0", r, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, d1, d2; bit e; int lat, nready, t1, t2, lowcnt;
    xfer(0, 0, 1, 32'h0, 32'hA5A50000, r, e, lat);
    xfer(0, 0, 1, 32'h4, 32'h5A5A0004, r, e, lat);
    @(negedge clk);
    rd[0] = 1'b1; ad[0] = 32'h0;
    nready = 0; t1 = -1; t2 = -1; lowcnt = 0; d1 = 32'hx; d2 = 32'hx;
    for (int c = 0; c < 20 && nready < 2; c++) begin
      @(negedge clk);
      if (ready_o[0]) begin
        nready++;
        if (nready == 1) begin
          t1 = c; d1 = rdata0; ad[0] = 32'h4;
        end else begin
          t2 = c; d2 = rdata0; rd[0] = 1'b0;
        end
      end else if (nready == 1 && !busy_o[0]) begin
        lowcnt++;
      end
    end
    rd[0] = 1'b0;
    last_rd[0] = 32'h5A5A0004;
    checks++;
    if (t1 !== 0) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=0", t1); end
    checks++;
    if (t2 - t1 !== 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=2", t2 - t1); end
    checks++;
    if (d1 !== 32'hA5A50000 || d2 !== 32'h5A5A0004) begin
      failures++; $display("FAIL b2b_data got=%h,%h exp=a5a50000,5a5a0004", d1, d2);
    end
    checks++;
    if (lowcnt !== 1) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=1", lowcnt); end
  endtask

  task automatic test_misaligned;
    logic [31:0] r; bit e; int lat;
    xfer(1, 1, 0, 32'h13, 32'h0, r, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b1) begin
      failures++; $display("FAIL misalign_resp got lat=%0d err=%b exp lat=1 err=1", lat, e);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL misalign_rdata got=%h exp=deadbeef", r); end
    xfer(1, 1, 0, 32'h10, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL misalign_mem got=%h exp=deadbeef", r); end
  endtask

  task automatic test_both_strobes;
    logic [31:0] r; bit e; int lat;
    xfer(1, 0, 1, 32'h20, 32'h11112222, r, e, lat);
    xfer(1, 1, 1, 32'h20, 32'h99998888, r, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b1) begin
      failures++; $display("FAIL both_resp got lat=%0d err=%b exp lat=1 err=1", lat, e);
    end
    xfer(1, 1, 0, 32'h20, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'h11112222 || e !== 1'b0) begin
      failures++; $display("FAIL both_mem got=%h err=%b exp=11112222 err=0", r, e);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] r; bit e; int lat;
    xfer(1, 0, 1, 32'h4 + 32'h1000, 32'h12345678, r, e, lat);
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", e); end
    xfer(1, 1, 0, 32'h4, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'h12345678) begin failures++; $display("FAIL wrap_data got=%h exp=12345678", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; bit e; int lat, seen;
    xfer(1, 0, 1, 32'h8, 32'h0BADC0DE, r, e, lat);
    @(negedge clk);
    wr[1] = 1'b1; ad[1] = 32'h8; wd[1] = 32'hCAFEF00D;
    @(negedge clk);
    nrst = 1'b0;
    wr[1] = 1'b0;
    #1;
    checks++;
    if ({ready_o[1], busy_o[1], err_o[1]} !== 3'b000 || rdata1 !== 32'h0) begin
      failures++; $display("FAIL midreset_outputs got rdy/busy/err=%b rdata=%h exp=000 0",
                           {ready_o[1], busy_o[1], err_o[1]}, rdata1);
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready_o[1] || busy_o[1]) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midreset_no_ready got=%0d cycles exp=0", seen); end
    xfer(1, 1, 0, 32'h8, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'h0BADC0DE) begin failures++; $display("FAIL midreset_mem got=%h exp=0badc0de", r); end
  endtask

  task automatic test_random;
    logic [31:0] a, wdat, r, ed; bit e, ee, rq, wq; int d, kind, idx, lat, el;
    for (int n = 0; n < 80; n++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      idx  = int'($urandom_range(0, 31));
      a    = ($urandom() & 32'hFFFF_F000) | 32'(idx * 4);
      wdat = $urandom();
      if (kind <= 1 && !mv[d][widx(a)]) kind = 2;
      rq = (kind <= 1) || (kind >= 4);
      wq = (kind == 2) || (kind == 3) || (kind == 4);
      if (kind == 5) a = a | 32'($urandom_range(1, 3));
      model_predict(d, rq, wq, a, el, ee, ed);
      xfer(d, rq, wq, a, wdat, r, e, lat);
      checks++;
      if (lat !== el || e !== ee) begin
        failures++; $display("FAIL rand_resp n=%0d dut%0d got lat=%0d err=%b exp lat=%0d err=%b",
                             n, d, lat, e, el, ee);
      end
      checks++;
      if (r !== ed) begin
        failures++; $display("FAIL rand_rdata n=%0d dut%0d addr=%h got=%h exp=%h", n, d, a, r, ed);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_misaligned();
    test_both_strobes();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
